// File: rtl/dlc_key_sender_pkg.sv
// Shared definitions for the DLC keypad sender and its tick divider.
`timescale 1ns/1ps
package dlc_key_sender_pkg;

    // FSM state encodings (fixed, visible on the debug port)
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_DRIVE = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    // Symbol encodings carried in the code word
    localparam logic SYM_X = 1'b0;
    localparam logic SYM_Y = 1'b1;

    // Clock divide ratio shared with the DLC receiver; never below 1
    function automatic int unsigned calc_div(input int unsigned old_hz,
                                             input int unsigned new_hz);
        if (new_hz == 0 || old_hz < new_hz) begin
            return 1;
        end
        return old_hz / new_hz;
    endfunction

endpackage

// File: rtl/dlc_key_sender_tick_gen.sv
// Free-running divider producing a 1-clock tick enable every DIV clocks.
`timescale 1ns/1ps
module dlc_tick_gen
    import dlc_key_sender_pkg::*;
#(
    parameter int unsigned OLD_HZ = 2,
    parameter int unsigned NEW_HZ = 1
) (
    input  logic iCLK,
    input  logic inRESET,
    output logic oTICK
);

    localparam int unsigned DIV   = calc_div(OLD_HZ, NEW_HZ);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    // With DIV=1 the counter stays at 0 and the tick is always high
    assign w_wrap = (r_cnt == CNT_W'(DIV - 1));
    assign oTICK  = w_wrap;

    // Divider counter, wraps after DIV clocks
    always_ff @(posedge iCLK or negedge inRESET) begin
        if (!inRESET) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dlc_key_sender.sv
// Replays a stored X/Y code onto oX/oY pulses at the tick rate, then waits
// for the lock's unlock feedback and records a sticky pass or fail.
`timescale 1ns/1ps
module dlc_key_sender
    import dlc_key_sender_pkg::*;
#(
    parameter int unsigned OLD_HZ   = 2,
    parameter int unsigned NEW_HZ   = 1,
    parameter int unsigned CODE_LEN = 5,
    parameter int unsigned TIMEOUT  = 4
) (
    input  logic                iCLK,
    input  logic                inRESET,
    input  logic                iSEND,
    input  logic                iABORT,
    input  logic [CODE_LEN-1:0] iCODE,
    input  logic                iUNLOCK,
    output logic                oX,
    output logic                oY,
    output logic                oBUSY,
    output logic                oPASS,
    output logic                oFAIL,
    output logic [2:0]          oSTATE
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

    logic                w_tick;
    logic [2:0]          r_state, w_state_d;
    logic [CODE_LEN-1:0] r_code, w_code_d, w_code_shift;
    logic [3:0]          r_idx, w_idx_d;
    logic [TIMER_W-1:0]  r_timer, w_timer_d;
    logic                r_x, w_x_d;
    logic                r_y, w_y_d;
    logic                r_busy, w_busy_d;
    logic                r_pass, w_pass_d;
    logic                r_fail, w_fail_d;

    dlc_tick_gen #(
        .OLD_HZ (OLD_HZ),
        .NEW_HZ (NEW_HZ)
    ) u_tick_gen (
        .iCLK    (iCLK),
        .inRESET (inRESET),
        .oTICK   (w_tick)
    );

    // Current symbol always sits in bit 0; shifting exposes the next one
    assign w_code_shift = r_code >> 1;

    // Next-state logic: FSM, shift register, index, CHECK timer, result flags
    always_comb begin
        w_state_d = r_state;
        w_code_d  = r_code;
        w_idx_d   = r_idx;
        w_timer_d = r_timer;
        w_x_d     = r_x;
        w_y_d     = r_y;
        w_busy_d  = r_busy;
        w_pass_d  = r_pass;
        w_fail_d  = r_fail;
        if (iABORT) begin
            // Abort drops the transfer but leaves the last result visible
            w_state_d = ST_IDLE;
            w_x_d     = 1'b0;
            w_y_d     = 1'b0;
            w_busy_d  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iSEND) begin
                        w_code_d  = iCODE;
                        w_idx_d   = '0;
                        w_timer_d = '0;
                        w_pass_d  = 1'b0;
                        w_fail_d  = 1'b0;
                        w_busy_d  = 1'b1;
                        w_state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_tick) begin
                        w_x_d     = (r_code[0] == SYM_X);
                        w_y_d     = (r_code[0] == SYM_Y);
                        w_state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (w_tick) begin
                        w_x_d     = 1'b0;
                        w_y_d     = 1'b0;
                        w_state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_idx == 4'(CODE_LEN - 1)) begin
                            w_timer_d = '0;
                            w_state_d = ST_CHECK;
                        end else begin
                            w_idx_d   = r_idx + 4'd1;
                            w_code_d  = w_code_shift;
                            w_x_d     = (w_code_shift[0] == SYM_X);
                            w_y_d     = (w_code_shift[0] == SYM_Y);
                            w_state_d = ST_DRIVE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (iUNLOCK) begin
                        w_pass_d  = 1'b1;
                        w_busy_d  = 1'b0;
                        w_state_d = ST_IDLE;
                    end else if (w_tick) begin
                        if (r_timer == TIMER_W'(TIMEOUT - 1)) begin
                            w_fail_d  = 1'b1;
                            w_busy_d  = 1'b0;
                            w_state_d = ST_IDLE;
                        end else begin
                            w_timer_d = r_timer + 1'b1;
                        end
                    end
                end
                default: begin
                    w_x_d     = 1'b0;
                    w_y_d     = 1'b0;
                    w_busy_d  = 1'b0;
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge iCLK or negedge inRESET) begin
        if (!inRESET) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_code  <= w_code_d;
            r_idx   <= w_idx_d;
            r_timer <= w_timer_d;
            r_x     <= w_x_d;
            r_y     <= w_y_d;
            r_busy  <= w_busy_d;
            r_pass  <= w_pass_d;
            r_fail  <= w_fail_d;
        end
    end

    assign oX     = r_x;
    assign oY     = r_y;
    assign oBUSY  = r_busy;
    assign oPASS  = r_pass;
    assign oFAIL  = r_fail;
    assign oSTATE = r_state;

endmodule
